sipo_deserializer: RTL and testbench

//  Serial-in/parallel-out receiver: the capture end of the PISO serial link. Collects WIDTH

---
 rtl/sipo_defs_pkg.sv | 14 +
 rtl/sipo_out_buf.sv | 32 +++
 rtl/sipo_deserializer.sv | 121 ++++++++++++
 tb/tb_sipo_deserializer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sipo_defs_pkg.sv
// Shared definitions for the SIPO deserializer: FSM state encoding and counter sizing.
package sipo_defs;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter must hold 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register for assembled words.
// Load wins over drain in the same cycle; po holds its last value while invalid.
module sipo_out_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_dat,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             full,
    output logic             drain
);

    assign full  = po_valid;
    assign drain = po_valid & po_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            po       <= '0;
            po_valid <= 1'b0;
        end else if (load) begin
            po       <= load_dat;
            po_valid <= 1'b1;
        end else if (drain) begin
            po_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver: start-framed bit capture into a one-entry output buffer.
// Word appears on po one clock after its last bit; dropped words and mid-word restarts raise sticky flags.
module sipo_deserializer
    import sipo_defs::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    input  logic             si_valid,
    input  logic             si_start,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    input  logic             err_clr
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [WIDTH-1:0] shifted, captured;
    logic             word_done, fe_set, ovr_set, load;
    logic             buf_full, buf_drain, buf_free;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] r, input logic b);
        if (MSB_FIRST)
            return {r[WIDTH-2:0], b};
        else
            return {b, r[WIDTH-1:1]};
    endfunction

    // A fresh bit #1 is just a shift into an empty register.
    assign shifted  = shift_in(sreg, si);
    assign captured = shift_in('0, si);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sreg_nxt  = sreg;
        word_done = 1'b0;
        fe_set    = 1'b0;
        case (state)
            IDLE: begin
                if (si_valid && si_start) begin
                    sreg_nxt  = captured;
                    cnt_nxt   = CW'(1);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (si_valid) begin
                    if (si_start) begin
                        sreg_nxt = captured;
                        cnt_nxt  = CW'(1);
                        fe_set   = 1'b1;
                    end else if (cnt == CW'(WIDTH - 1)) begin
                        sreg_nxt  = shifted;
                        cnt_nxt   = '0;
                        word_done = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        sreg_nxt = shifted;
                        cnt_nxt  = cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sreg  <= sreg_nxt;
        end
    end

    assign buf_free = !buf_full || buf_drain;
    assign load     = word_done && buf_free;
    assign ovr_set  = word_done && !buf_free;

    // Set events beat a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= ovr_set | (overrun & ~err_clr);
            frame_err <= fe_set | (frame_err & ~err_clr);
        end
    end

    assign busy = (state == SHIFT);

    sipo_out_buf #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_dat (shifted),
        .po       (po),
        .po_valid (po_valid),
        .po_ready (po_ready),
        .full     (buf_full),
        .drain    (buf_drain)
    );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Drives MSB-first and LSB-first deserializers with shared stimulus and checks both against a queue-based model.
module tb_sipo_deserializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, si, si_valid, si_start, po_ready, err_clr;
    logic [W-1:0] po_m, po_l;
    logic         pv_m, pv_l, busy_m, busy_l, ovr_m, ovr_l, fe_m, fe_l;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    bit           bits_q[$];
    logic [W-1:0] e_po_m, e_po_l;
    logic         e_v, e_ovr, e_fe;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .si(si), .si_valid(si_valid), .si_start(si_start),
        .po(po_m), .po_valid(pv_m), .po_ready(po_ready), .busy(busy_m),
        .overrun(ovr_m), .frame_err(fe_m), .err_clr(err_clr)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .si(si), .si_valid(si_valid), .si_start(si_start),
        .po(po_l), .po_valid(pv_l), .po_ready(po_ready), .busy(busy_l),
        .overrun(ovr_l), .frame_err(fe_l), .err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    endtask

    // Applies the inputs sampled at this edge to the model.
    task automatic model_step();
        bit   done, ovr_set, fe_set, free, xfer;
        int   wm, wl;
        if (rst) begin
            bits_q.delete();
            e_po_m = '0; e_po_l = '0;
            e_v = 1'b0; e_ovr = 1'b0; e_fe = 1'b0;
            return;
        end
        xfer    = e_v && po_ready;
        free    = !e_v || po_ready;
        done    = 1'b0;
        ovr_set = 1'b0;
        fe_set  = 1'b0;
        if (si_valid) begin
            if (si_start) begin
                if (bits_q.size() > 0) fe_set = 1'b1;
                bits_q.delete();
                bits_q.push_back(si);
            end else if (bits_q.size() > 0) begin
                bits_q.push_back(si);
                if (bits_q.size() == W) done = 1'b1;
            end
        end
        if (done) begin
            wm = 0; wl = 0;
            for (int i = 0; i < W; i++) begin
                wm += int'(bits_q[i]) * (1 << (W - 1 - i));
                wl += int'(bits_q[i]) * (1 << i);
            end
            bits_q.delete();
            if (free) begin
                e_po_m = W'(wm);
                e_po_l = W'(wl);
                e_v    = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (xfer) begin
            e_v = 1'b0;
        end
        e_ovr = ovr_set || (e_ovr && !err_clr);
        e_fe  = fe_set || (e_fe && !err_clr);
    endtask

    task automatic compare_all();
        logic e_busy;
        e_busy = (bits_q.size() > 0);
        check("po_msb",   32'(po_m),   32'(e_po_m));
        check("po_lsb",   32'(po_l),   32'(e_po_l));
        check("pv_msb",   32'(pv_m),   32'(e_v));
        check("pv_lsb",   32'(pv_l),   32'(e_v));
        check("busy_msb", 32'(busy_m), 32'(e_busy));
        check("busy_lsb", 32'(busy_l), 32'(e_busy));
        check("ovr_msb",  32'(ovr_m),  32'(e_ovr));
        check("ovr_lsb",  32'(ovr_l),  32'(e_ovr));
        check("fe_msb",   32'(fe_m),   32'(e_fe));
        check("fe_lsb",   32'(fe_l),   32'(e_fe));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic bit_in(input logic b, input logic st);
        si = b; si_valid = 1'b1; si_start = st;
        tick();
        si_valid = 1'b0; si_start = 1'b0;
    endtask

    task automatic idle(input int n);
        si_valid = 1'b0; si_start = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_word(input logic [W-1:0] w);
        logic [W-1:0] t;
        t = w;
        for (int i = W - 1; i >= 0; i--) bit_in(t[i], i == W - 1);
    endtask

    initial begin
        rst = 1'b1; si = 1'b0; si_valid = 1'b0; si_start = 1'b0;
        po_ready = 1'b1; err_clr = 1'b0;
        repeat (2) tick();
        check("rst_po", 32'(po_m), 0);
        check("rst_pv", 32'(pv_m), 0);
        rst = 1'b0;
        idle(1);

        // Bits 1,0,1,1: MSB-first gives B, LSB-first gives D.
        bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
        check("t1_busy_pre", 32'(busy_m), 1);
        bit_in(1'b1, 1'b0);
        check("t1_po_msb", 32'(po_m), 32'h B);
        check("t2_po_lsb", 32'(po_l), 32'h D);
        check("t1_pv", 32'(pv_m), 1);
        check("t1_busy", 32'(busy_m), 0);
        idle(1);
        check("t1_pv_drop", 32'(pv_m), 0);

        // Gaps of two idle cycles between bits.
        bit_in(1'b0, 1'b1); idle(2);
        bit_in(1'b1, 1'b0); idle(2);
        check("t3_busy_gap", 32'(busy_m), 1);
        bit_in(1'b0, 1'b0); idle(2);
        bit_in(1'b1, 1'b0);
        check("t3_po", 32'(po_m), 32'h5);
        idle(2);

        // Back-pressure and overrun.
        po_ready = 1'b0;
        send_word(4'hA);
        send_word(4'h5);
        check("t4_po_held", 32'(po_m), 32'h A);
        check("t4_ovr", 32'(ovr_m), 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("t4_ovr_clr", 32'(ovr_m), 0);
        check("t4_pv_held", 32'(pv_m), 1);
        po_ready = 1'b1; tick();
        check("t4_pv_xfer", 32'(pv_m), 0);
        idle(1);

        // Early restart mid-word.
        bit_in(1'b1, 1'b1); bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b1); bit_in(1'b1, 1'b0); bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0);
        check("t5_fe", 32'(fe_m), 1);
        check("t5_po", 32'(po_m), 32'h6);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("t5_fe_clr", 32'(fe_m), 0);
        idle(2);

        // Reset mid-word; bits without a start are ignored afterwards.
        bit_in(1'b1, 1'b1); bit_in(1'b0, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t6_po", 32'(po_m), 0);
        check("t6_busy", 32'(busy_m), 0);
        for (int i = 0; i < W; i++) bit_in(1'b1, 1'b0);
        check("t6_no_pv", 32'(pv_m), 0);
        idle(1);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 249) == 0);
            si_valid = ($urandom_range(0, 2) != 0);
            si_start = si_valid && ($urandom_range(0, 5) == 0);
            si       = 1'($urandom);
            po_ready = ($urandom_range(0, 3) != 0);
            err_clr  = ($urandom_range(0, 30) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
